// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the sprite clients, the sprite ROM and the arbiter.
// slave: the arbiter side. master: the clients/ROM side driving requests and data.
`timescale 1ns/1ps
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 5
) ();
  logic              req0;
  logic              req1;
  logic [6:0]        row0;
  logic [6:0]        row1;
  logic              gnt0;
  logic              gnt1;
  logic              err;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic [6:0]        pix_col;
  logic              pix_owner;
  logic              pix_last;
  logic              busy;

  modport slave (
    input  req0, req1, row0, row1, rom_data,
    output gnt0, gnt1, err, rom_addr, pix_data, pix_valid, pix_col,
           pix_owner, pix_last, busy
  );

  modport master (
    output req0, req1, row0, row1, rom_data,
    input  gnt0, gnt1, err, rom_addr, pix_data, pix_valid, pix_col,
           pix_owner, pix_last, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Two-client sprite ROM arbiter. A granted client gets one full sprite row
// streamed out as SPRITE_W consecutive pixels; rows outside the sprite are
// acknowledged with err and never touch the ROM.
`timescale 1ns/1ps
module sprite_rom_arbiter #(
  parameter int SPRITE_W = 70,
  parameter int SPRITE_H = 70,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 5
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_rom_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [6:0] LAST_COL = 7'(SPRITE_W - 1);
  localparam logic [7:0] ROW_LIM  = 8'(SPRITE_H);

  state_t            state_reg, state_next;
  logic [6:0]        col_reg, col_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [ADDR_W-1:0] rom_addr_reg, rom_addr_next;
  logic              owner_reg, owner_next;
  logic              prio1_reg, prio1_next;   // 1: client 1 wins the next tie
  logic              gnt0_reg, gnt0_next;
  logic              gnt1_reg, gnt1_next;
  logic              err_reg, err_next;
  logic              pix_valid_reg, pix_valid_next;
  logic [6:0]        pix_col_reg, pix_col_next;
  logic              pix_owner_reg, pix_owner_next;
  logic              pix_last_reg, pix_last_next;

  logic              any_req;
  logic              pick;                    // selected client index
  logic [6:0]        pick_row;
  logic              row_bad;
  logic              issue_last;
  logic [ADDR_W-1:0] pick_row_ext;
  logic [ADDR_W-1:0] pick_base;
  logic [DATA_W-1:0] pix_data_w;

  assign any_req      = bus.req0 | bus.req1;
  assign pick         = (bus.req0 & bus.req1) ? prio1_reg : bus.req1;
  assign pick_row     = pick ? bus.row1 : bus.row0;
  assign row_bad      = ({1'b0, pick_row} >= ROW_LIM);
  assign issue_last   = (col_reg == LAST_COL);
  assign pick_row_ext = ADDR_W'(pick_row);

  // Row base address; the default 70-pixel width is 64+4+2, so shifts suffice.
  generate
    if (SPRITE_W == 70) begin : g_base_shift
      assign pick_base = (pick_row_ext << 6) + (pick_row_ext << 2) + (pick_row_ext << 1);
    end else begin : g_base_mul
      assign pick_base = pick_row_ext * ADDR_W'(SPRITE_W);
    end
  endgenerate

  // Next-state, arbitration and address generation.
  always_comb begin
    state_next     = state_reg;
    col_next       = col_reg;
    base_next      = base_reg;
    owner_next     = owner_reg;
    prio1_next     = prio1_reg;
    gnt0_next      = 1'b0;
    gnt1_next      = 1'b0;
    err_next       = 1'b0;
    rom_addr_next  = '0;
    // Pixel qualifiers trail the issued address by one cycle, matching ROM latency.
    pix_valid_next = (state_reg == ISSUE);
    pix_col_next   = (state_reg == ISSUE) ? col_reg : 7'd0;
    pix_owner_next = (state_reg == ISSUE) ? owner_reg : 1'b0;
    pix_last_next  = (state_reg == ISSUE) && issue_last;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          gnt0_next  = ~pick;
          gnt1_next  = pick;
          prio1_next = ~pick;
          if (row_bad) begin
            err_next = 1'b1;
          end else begin
            state_next    = ISSUE;
            col_next      = 7'd0;
            base_next     = pick_base;
            owner_next    = pick;
            rom_addr_next = pick_base;
          end
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_next = DRAIN;
          col_next   = 7'd0;
        end else begin
          col_next      = col_reg + 7'd1;
          rom_addr_next = base_reg + ADDR_W'(col_reg + 7'd1);
        end
      end
      DRAIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops everything at once, aborting any burst.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg     <= IDLE;
      col_reg       <= 7'd0;
      base_reg      <= '0;
      rom_addr_reg  <= '0;
      owner_reg     <= 1'b0;
      prio1_reg     <= 1'b0;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      err_reg       <= 1'b0;
      pix_valid_reg <= 1'b0;
      pix_col_reg   <= 7'd0;
      pix_owner_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      col_reg       <= col_next;
      base_reg      <= base_next;
      rom_addr_reg  <= rom_addr_next;
      owner_reg     <= owner_next;
      prio1_reg     <= prio1_next;
      gnt0_reg      <= gnt0_next;
      gnt1_reg      <= gnt1_next;
      err_reg       <= err_next;
      pix_valid_reg <= pix_valid_next;
      pix_col_reg   <= pix_col_next;
      pix_owner_reg <= pix_owner_next;
      pix_last_reg  <= pix_last_next;
    end
  end

  assign pix_data_w    = bus.rom_data;
  assign bus.pix_data  = pix_data_w;
  assign bus.gnt0      = gnt0_reg;
  assign bus.gnt1      = gnt1_reg;
  assign bus.err       = err_reg;
  assign bus.rom_addr  = rom_addr_reg;
  assign bus.pix_valid = pix_valid_reg;
  assign bus.pix_col   = pix_col_reg;
  assign bus.pix_owner = pix_owner_reg;
  assign bus.pix_last  = pix_last_reg;
  assign bus.busy      = (state_reg != IDLE);

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter SPRITE_W, default 70: sprite width in pixels (columns per row burst).
REQ-002 Parameter SPRITE_H, default 70: sprite height in rows; valid rows 0..SPRITE_H-1.
REQ-003 Parameter ADDR_W, default 13: sprite ROM address width.
REQ-004 Parameter DATA_W, default 5: palette-index width of ROM data.
REQ-005 Clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 req0 / req1  input  1 each  client burst request, level, held until matching gnt.
REQ-008 row0 / row1  input  7 each  sprite row requested by client 0 / 1.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, row sampled.
REQ-010 err  output  1  one-cycle pulse with gnt when the accepted row >= SPRITE_H.
REQ-011 rom_addr  output  ADDR_W  registered address to the sprite ROM.
REQ-012 rom_data  input  DATA_W  ROM read data, valid one cycle after rom_addr.
REQ-013 pix_data  output  DATA_W  equals rom_data (combinational pass-through).
REQ-014 pix_valid  output  1  pix_data is a returned pixel of the current burst.
REQ-015 pix_col  output  7  column index (0..SPRITE_W-1) of pix_data.
REQ-016 pix_owner  output  1  client (0/1) that owns the current pixel.
REQ-017 pix_last  output  1  high with the column SPRITE_W-1 pixel only.
REQ-018 busy  output  1  high in ISSUE and DRAIN states.

Function
REQ-019 FSM states IDLE, ISSUE, DRAIN; reset state IDLE.
REQ-020 IDLE: at a rising edge with req0 or req1 high, the block SHALL select one client, latch its row, pulse its gnt in the following cycle, and enter ISSUE (or stay IDLE if err).
REQ-021 Arbitration: single requester wins; both requesting -> the client not granted last wins; after reset client 0 wins a tie.
REQ-022 The last-granted pointer SHALL update on every gnt, including err grants.
REQ-023 Row >= SPRITE_H: gnt and err pulse together, no ROM access, no pix_valid, state remains IDLE.
REQ-024 Base address = row*SPRITE_W, computed without a multiplier at default parameters (row*64 + row*4 + row*2), ADDR_W-bit result; max address 4899.
REQ-025 ISSUE: rom_addr = base + col for col 0..SPRITE_W-1, one per cycle, col 0 in the first ISSUE cycle (the gnt cycle).
REQ-026 After col SPRITE_W-1 is issued, the next state is DRAIN for exactly one cycle, then IDLE.
REQ-027 pix_valid, pix_col, pix_owner, pix_last SHALL be the ISSUE-cycle values registered by one cycle, aligning them with rom_data.
REQ-028 A burst yields exactly SPRITE_W consecutive pix_valid cycles, no gaps, columns strictly increasing.
REQ-029 Outside ISSUE, rom_addr SHALL be 0; pix_col, pix_owner, pix_last SHALL be 0 when pix_valid is 0.
REQ-030 Requests arriving during ISSUE/DRAIN are held off (no gnt) until IDLE; minimum gap between the last pix_valid and the next burst's first pix_valid is 2 cycles.
REQ-031 req still high in IDLE after its gnt is a new request.
REQ-032 row inputs are ignored except on the granting edge; changes mid-burst SHALL NOT affect addresses.

Reset
REQ-033 Reset_n low SHALL immediately force: state IDLE, gnt0=gnt1=0, err=0, rom_addr=0, pix_valid=0, pix_col=0, pix_owner=0, pix_last=0, busy=0, tie pointer to client 0.
REQ-034 Reset asserted mid-burst SHALL abort the burst with no further pix_valid; after release, arbitration restarts from IDLE.

Verification
REQ-035 req0=1, row0=0 -> gnt0 pulse; rom_addr 0..69; pix_valid 70 cycles, pix_col 0..69, pix_last at col 69, pix_owner=0.
REQ-036 req1=1, row1=69 -> rom_addr 4830..4899; pix_owner=1; busy high 71 cycles.
REQ-037 req0 and req1 both high from reset -> gnt0 first, then gnt1; 2 idle cycles between bursts; a third tie grants client 0.
REQ-038 req0=1, row0=70 -> gnt0 and err same cycle; pix_valid stays 0; rom_addr stays 0; busy stays 0.
REQ-039 Reset_n pulled low at pix_col=30 of a burst -> all outputs 0 asynchronously; after release with req1=1, row1=5 -> gnt1, rom_addr starts at 350.
REQ-040 row0 changed from 2 to 9 mid-burst -> addresses continue 140..209 unaffected.
